thru_out_edge_monitor: RTL and testbench



---
 rtl/thru_out_edge_monitor.sv | 187 ++++++++++++++++++
 tb/tb_thru_out_edge_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thru_out_edge_monitor.sv
// Synchronizes and debounces an analog output node, counts debounced edges per window
// and hands each window's counts out over valid/ready. Optional macro: THRU_MON_GLITCH_CNT_EN.
module thru_out_edge_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEB_CYC = 4,
    parameter int unsigned WIN_CYC = 1024,
    parameter int unsigned WIN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             node_in,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_rise,
    output logic [CNT_W-1:0] rpt_fall,
`ifdef THRU_MON_GLITCH_CNT_EN
    output logic [CNT_W-1:0] rpt_glitch,
`endif
    output logic             rpt_ovf
);

    localparam int unsigned      DEB_W    = 8;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state_q, state_d;
    logic               s1, s2;
    logic               level_prev;
    logic [DEB_W-1:0]   deb_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic               win_end;
    logic [CNT_W-1:0]   rise_cnt, fall_cnt;
    logic [CNT_W-1:0]   rise_snap, fall_snap;
    logic               load;
    logic               valid_d, ovf_d;
    logic [CNT_W-1:0]   rise_d, fall_d;

    // Two-flop synchronizer for the asynchronous node level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= node_in;
            s2 <= s1;
        end
    end

    // Debounce: accept a new level after DEB_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 1'b0;
            deb_cnt <= '0;
        end else if (s2 == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            level   <= s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // Edge pulses trail the level change by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            level_prev <= level;
            rise_pulse <= level & ~level_prev;
            fall_pulse <= ~level & level_prev;
        end
    end

    assign win_end = (win_cnt == WIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       win_cnt <= '0;
        else if (win_end) win_cnt <= '0;
        else              win_cnt <= win_cnt + WIN_W'(1);
    end

    // Snapshot values include a pulse landing in the window's last cycle
    always_comb begin
        rise_snap = rise_cnt;
        fall_snap = fall_cnt;
        if (rise_pulse && (rise_cnt != CNT_MAX)) rise_snap = rise_cnt + CNT_W'(1);
        if (fall_pulse && (fall_cnt != CNT_MAX)) fall_snap = fall_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
        end else if (win_end) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
        end else begin
            rise_cnt <= rise_snap;
            fall_cnt <= fall_snap;
        end
    end

`ifdef THRU_MON_GLITCH_CNT_EN
    logic             glitch_ev;
    logic [CNT_W-1:0] glitch_cnt, glitch_snap, glitch_d;

    // A rejected glitch: the sample returns to the held level mid-debounce
    assign glitch_ev = (s2 == level) && (deb_cnt != '0);

    always_comb begin
        glitch_snap = glitch_cnt;
        if (glitch_ev && (glitch_cnt != CNT_MAX)) glitch_snap = glitch_cnt + CNT_W'(1);
        glitch_d = rpt_glitch;
        if (load) glitch_d = glitch_snap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
            rpt_glitch <= '0;
        end else begin
            glitch_cnt <= win_end ? '0 : glitch_snap;
            rpt_glitch <= glitch_d;
        end
    end
`endif

    // Report FSM next-state and next report register values
    always_comb begin
        state_d = state_q;
        valid_d = rpt_valid;
        rise_d  = rpt_rise;
        fall_d  = rpt_fall;
        ovf_d   = rpt_ovf;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_end) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (win_end) begin
                    if (rpt_ready) load  = 1'b1;
                    else           ovf_d = 1'b1;
                end else if (rpt_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            rise_d = rise_snap;
            fall_d = fall_snap;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rpt_valid <= 1'b0;
            rpt_rise  <= '0;
            rpt_fall  <= '0;
            rpt_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_valid <= valid_d;
            rpt_rise  <= rise_d;
            rpt_fall  <= fall_d;
            rpt_ovf   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_thru_out_edge_monitor.sv
// Scoreboard bench for thru_out_edge_monitor: expected window reports are queued from
// the bench's own stimulus timeline and compared while the DUT presents them.
module tb_thru_out_edge_monitor;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DEB_CYC = 4;
    localparam int unsigned WIN_CYC = 256;
    localparam int unsigned WIN_W   = 8;
    localparam int          LAT     = DEB_CYC + 4;  // node edge to counted edge
    localparam int          CMAX    = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             node_in = 1'b0;
    logic             rpt_ready = 1'b1;
    logic             level, rise_pulse, fall_pulse, rpt_valid, rpt_ovf;
    logic [CNT_W-1:0] rpt_rise, rpt_fall;
`ifdef THRU_MON_GLITCH_CNT_EN
    logic [CNT_W-1:0] rpt_glitch;
`endif

    thru_out_edge_monitor #(
        .CNT_W(CNT_W), .DEB_CYC(DEB_CYC), .WIN_CYC(WIN_CYC), .WIN_W(WIN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .node_in(node_in),
        .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_rise(rpt_rise), .rpt_fall(rpt_fall),
`ifdef THRU_MON_GLITCH_CNT_EN
        .rpt_glitch(rpt_glitch),
`endif
        .rpt_ovf(rpt_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int f;
        int ovf;
    } rpt_t;

    rpt_t exp_q[$];
    int   exp_r[int];
    int   exp_f[int];
    int   cyc;
    logic rdy_q;
    logic pend_m = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   win_m;
    rpt_t e_w;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    // Edges since reset release; edge n closes window n/WIN_CYC when n is a multiple
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) rdy_q <= rpt_ready;

    // Report model and scoreboard, evaluated mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_m = 1'b0;
            exp_q.delete();
        end else begin
            if (cyc > 0) begin
                if (cyc % WIN_CYC == 0) begin
                    win_m = cyc / WIN_CYC;
                    e_w.r   = sat(exp_r.exists(win_m) ? exp_r[win_m] : 0);
                    e_w.f   = sat(exp_f.exists(win_m) ? exp_f[win_m] : 0);
                    e_w.ovf = 0;
                    if (!pend_m) begin
                        exp_q.push_back(e_w);
                        pend_m = 1'b1;
                    end else if (rdy_q) begin
                        exp_q.push_back(e_w);
                    end else if (exp_q.size() > 0) begin
                        e_w = exp_q.pop_back();
                        e_w.ovf = 1;
                        exp_q.push_back(e_w);
                    end
                end else if (pend_m && rdy_q) begin
                    pend_m = 1'b0;
                end
            end
            check_val("rpt_valid", int'(rpt_valid), int'(pend_m));
            if (rpt_valid && exp_q.size() > 0) begin
                check_val("rpt_rise", int'(rpt_rise), exp_q[0].r);
                check_val("rpt_fall", int'(rpt_fall), exp_q[0].f);
                check_val("rpt_ovf", int'(rpt_ovf), exp_q[0].ovf);
                if (rpt_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick(1);
    endtask

    // Clean transition: record which window will count it
    task automatic drive(input logic v);
        int m;
        node_in = v;
        m = (cyc + LAT + int'(WIN_CYC) - 1) / int'(WIN_CYC);
        if (v) exp_r[m] = (exp_r.exists(m) ? exp_r[m] : 0) + 1;
        else   exp_f[m] = (exp_f.exists(m) ? exp_f[m] : 0) + 1;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            drive(1'b1);
            tick(hi);
            drive(1'b0);
            tick(lo);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_level"}, int'(level), 0);
        check_val({tag, "_rise_pulse"}, int'(rise_pulse), 0);
        check_val({tag, "_fall_pulse"}, int'(fall_pulse), 0);
        check_val({tag, "_valid"}, int'(rpt_valid), 0);
        check_val({tag, "_rise"}, int'(rpt_rise), 0);
        check_val({tag, "_fall"}, int'(rpt_fall), 0);
        check_val({tag, "_ovf"}, int'(rpt_ovf), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
        $fatal(1);
    end

    initial begin
        #1 check_zero("reset");
        tick(3);
        rst_n = 1'b1;

        // Debounce latency and a rejected short pulse
        wait_until(10);
        drive(1'b1);
        for (int j = 1; j <= 8; j++) begin
            tick(1);
            check_val("lat_level", int'(level), (j >= 6) ? 1 : 0);
            check_val("lat_rise_pulse", int'(rise_pulse), (j == 7) ? 1 : 0);
        end
        tick(10);
        drive(1'b0);
        tick(12);
        node_in = 1'b1;
        tick(3);
        node_in = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick(1);
            check_val("glitch_level", int'(level), 0);
            check_val("glitch_rise_pulse", int'(rise_pulse), 0);
        end

        // Five clean pulses in window 2
        wait_until(WIN_CYC);
        pulses(5, 10, 10);
        wait_until(2 * WIN_CYC);
        check_val("win2_rise", int'(rpt_rise), 5);
        check_val("win2_fall", int'(rpt_fall), 5);

        // Rise counted in the closing window's last cycle, fall in the next window
        wait_until(3 * WIN_CYC - LAT);
        drive(1'b1);
        tick(6);
        drive(1'b0);
        wait_until(3 * WIN_CYC);
        check_val("edge_last_rise", int'(rpt_rise), 1);
        check_val("edge_last_fall", int'(rpt_fall), 0);

        // Backpressure across three window ends
        wait_until(4 * WIN_CYC + 6);
        rpt_ready = 1'b0;
        wait_until(4 * WIN_CYC + 16);
        pulses(2, 8, 8);
        wait_until(5 * WIN_CYC + 10);
        pulses(3, 8, 8);
        wait_until(6 * WIN_CYC + 4);
        check_val("bp_ovf", int'(rpt_ovf), 1);
        check_val("bp_hold_rise", int'(rpt_rise), 2);
        wait_until(7 * WIN_CYC + 8);
        rpt_ready = 1'b1;
        tick(1);
        rpt_ready = 1'b0;
        check_val("bp_drop_valid", int'(rpt_valid), 0);
        check_val("bp_data_hold", int'(rpt_fall), 2);

        // Ready coinciding with a window end while a report is pending
        wait_until(7 * WIN_CYC + 18);
        pulses(1, 10, 10);
        wait_until(8 * WIN_CYC + 12);
        pulses(4, 10, 10);
        wait_until(9 * WIN_CYC - 1);
        rpt_ready = 1'b1;
        tick(1);
        check_val("sim_valid", int'(rpt_valid), 1);
        check_val("sim_rise", int'(rpt_rise), 4);
        check_val("sim_ovf", int'(rpt_ovf), 0);

        // Saturation of the edge counters
        wait_until(10 * WIN_CYC);
        pulses(20, 6, 6);
        wait_until(11 * WIN_CYC);
        check_val("sat_rise", int'(rpt_rise), 15);
        check_val("sat_fall", int'(rpt_fall), 15);
        wait_until(12 * WIN_CYC);
        check_val("after_sat_rise", int'(rpt_rise), 0);

        // Asynchronous reset in mid-operation
        pulses(25, 10, 10);
        drive(1'b1);
        tick(8);
        check_val("pre_reset_level", int'(level), 1);
        #2;
        rst_n = 1'b0;
        node_in = 1'b0;
        exp_r.delete();
        exp_f.delete();
        #1 check_zero("async_reset");
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < int'(WIN_CYC) + 10; i++) begin
            tick(1);
            if (rpt_valid) break;
        end
        check_val("first_rpt_cycle", cyc, int'(WIN_CYC));
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
